// File: rtl/home_automation_pkg.sv
// rtl/home_automation_pkg.sv - shared sensor indices and conditioning defaults
package home_automation_pkg;

  localparam int NUM_SENSORS = 5;

  localparam int IDX_SFD = 0;
  localparam int IDX_SRD = 1;
  localparam int IDX_SFA = 2;
  localparam int IDX_SW  = 3;
  localparam int IDX_ST  = 4;

  localparam int DEFAULT_TEMP_W             = 6;
  localparam int DEFAULT_DEBOUNCE_CYCLES    = 4;
  localparam int DEFAULT_TEMP_STABLE_CYCLES = 2;

  // Counter width for a terminal count of n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// rtl/debounce_bit.sv - two-flop synchroniser and debouncer for one binary sensor
module debounce_bit
  import home_automation_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic clean,
  output logic flip
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  // High on the edge where the output is about to take the synchronised level.
  assign flip = (s2 != clean) && (cnt == CNT_LAST);

  // Two-stage synchroniser for the asynchronous sensor level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // Count consecutive disagreements; any agreement restarts the count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      clean <= 1'b0;
    end else if (s2 == clean) begin
      cnt <= '0;
    end else if (flip) begin
      clean <= s2;
      cnt   <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/sensor_conditioner.sv
// rtl/sensor_conditioner.sv - synchronise, debounce and filter the home sensors
module sensor_conditioner
  import home_automation_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES    = DEFAULT_DEBOUNCE_CYCLES,
  parameter int TEMP_STABLE_CYCLES = DEFAULT_TEMP_STABLE_CYCLES,
  parameter int TEMP_W             = DEFAULT_TEMP_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              SFD_raw,
  input  logic              SRD_raw,
  input  logic              SFA_raw,
  input  logic              SW_raw,
  input  logic              ST_raw,
  input  logic [TEMP_W-1:0] temperature_raw,
  output logic              SFD,
  output logic              SRD,
  output logic              SFA,
  output logic              SW,
  output logic              ST,
  output logic [TEMP_W-1:0] temperature,
  output logic              any_active,
  output logic              sensor_change
);

  localparam int SW_CNT = cnt_width(TEMP_STABLE_CYCLES);
  localparam logic [SW_CNT-1:0] STAB_LAST = SW_CNT'(TEMP_STABLE_CYCLES - 1);

  logic [NUM_SENSORS-1:0] raw;
  logic [NUM_SENSORS-1:0] clean;
  logic [NUM_SENSORS-1:0] flip;

  logic [TEMP_W-1:0] t_s1;
  logic [TEMP_W-1:0] t_s2;
  logic [TEMP_W-1:0] hold;
  logic [SW_CNT-1:0] stab_cnt;
  logic              temp_pub;

  assign raw[IDX_SFD] = SFD_raw;
  assign raw[IDX_SRD] = SRD_raw;
  assign raw[IDX_SFA] = SFA_raw;
  assign raw[IDX_SW]  = SW_raw;
  assign raw[IDX_ST]  = ST_raw;

  for (genvar gi = 0; gi < NUM_SENSORS; gi++) begin : g_db
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk   (clk),
      .reset (reset),
      .raw   (raw[gi]),
      .clean (clean[gi]),
      .flip  (flip[gi])
    );
  end

  assign SFD = clean[IDX_SFD];
  assign SRD = clean[IDX_SRD];
  assign SFA = clean[IDX_SFA];
  assign SW  = clean[IDX_SW];
  assign ST  = clean[IDX_ST];

  assign any_active = |clean;

  // The held code has been steady long enough and differs from what is published.
  assign temp_pub = (t_s2 == hold) && (hold != temperature) && (stab_cnt == STAB_LAST);

  // Bit-wise synchroniser; skew between bits is absorbed by the stability filter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      t_s1 <= '0;
      t_s2 <= '0;
    end else begin
      t_s1 <= temperature_raw;
      t_s2 <= t_s1;
    end
  end

  // Publish the held code only once it has stayed constant for the full window.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold        <= '0;
      stab_cnt    <= '0;
      temperature <= '0;
    end else if (t_s2 != hold) begin
      hold     <= t_s2;
      stab_cnt <= '0;
    end else if (temp_pub) begin
      temperature <= hold;
      stab_cnt    <= '0;
    end else if (hold != temperature) begin
      stab_cnt <= stab_cnt + SW_CNT'(1);
    end else begin
      stab_cnt <= '0;
    end
  end

  // One pulse per edge on which any conditioned output changes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sensor_change <= 1'b0;
    end else begin
      sensor_change <= (|flip) || temp_pub;
    end
  end

endmodule

// File: tb/tb_sensor_conditioner.sv
// tb/tb_sensor_conditioner.sv - randomized self-checking bench for sensor_conditioner
module tb_sensor_conditioner;
  import home_automation_pkg::*;

  localparam int D  = 4;
  localparam int T  = 2;
  localparam int TW = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    raw_b;
  logic [TW-1:0] raw_t;

  logic          SFD, SRD, SFA, SW, ST;
  logic [TW-1:0] temperature;
  logic          any_active;
  logic          sensor_change;

  logic [13:0]   obs;
  logic [4:0]    dut_b;

  int errors = 0;
  int checks = 0;

  logic [4:0]    hb[$];
  logic [TW-1:0] ht[$];
  logic [4:0]    m_out;
  logic [TW-1:0] m_temp;
  logic          m_sc;

  always #5 clk = ~clk;

  sensor_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .TEMP_STABLE_CYCLES(T),
    .TEMP_W(TW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .SFD_raw         (raw_b[IDX_SFD]),
    .SRD_raw         (raw_b[IDX_SRD]),
    .SFA_raw         (raw_b[IDX_SFA]),
    .SW_raw          (raw_b[IDX_SW]),
    .ST_raw          (raw_b[IDX_ST]),
    .temperature_raw (raw_t),
    .SFD             (SFD),
    .SRD             (SRD),
    .SFA             (SFA),
    .SW              (SW),
    .ST              (ST),
    .temperature     (temperature),
    .any_active      (any_active),
    .sensor_change   (sensor_change)
  );

  assign dut_b = {ST, SW, SFA, SRD, SFD};
  assign obs   = {temperature, any_active, sensor_change, dut_b};

  // Synchronised value seen just before edge n (1-based since reset release).
  function automatic logic [4:0] s2b(int n);
    if (n >= 3) return hb[n-3];
    return '0;
  endfunction

  function automatic logic [TW-1:0] s2t(int n);
    if (n >= 3) return ht[n-3];
    return '0;
  endfunction

  function automatic logic [13:0] exp_vec();
    return {m_temp, |m_out, m_sc, m_out};
  endfunction

  task automatic model_clear();
    hb.delete();
    ht.delete();
    m_out  = '0;
    m_temp = '0;
    m_sc   = 1'b0;
  endtask

  // One clock: record sampled inputs, advance the reference, return at negedge.
  // A sensor flips when its last D synchronised samples all disagree with it;
  // temperature is published when its last T+1 synchronised samples agree on a new code.
  task automatic tick();
    logic [4:0]    nb;
    logic [4:0]    v;
    logic [TW-1:0] nt;
    logic [TW-1:0] tv;
    bit            ok;
    int            n;
    @(posedge clk);
    hb.push_back(raw_b);
    ht.push_back(raw_t);
    n  = hb.size();
    nb = m_out;
    for (int i = 0; i < 5; i++) begin
      ok = (n >= D);
      for (int k = 0; k < D; k++) begin
        if (ok) begin
          v = s2b(n - k);
          if (v[i] == m_out[i]) ok = 1'b0;
        end
      end
      if (ok) nb[i] = ~m_out[i];
    end
    nt = m_temp;
    tv = s2t(n);
    ok = (n > T);
    for (int k = 1; k <= T; k++) begin
      if (ok && s2t(n - k) != tv) ok = 1'b0;
    end
    if (ok && tv != m_temp) nt = tv;
    m_sc   = (nb != m_out) || (nt != m_temp);
    m_out  = nb;
    m_temp = nt;
    @(negedge clk);
  endtask

  task automatic do_reset(int cyc);
    reset = 1'b0;
    model_clear();
    repeat (cyc) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    raw_b = 5'h1F;
    raw_t = '0;
    reset = 1'b0;
    model_clear();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (obs !== 14'h0) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d got=%h want=%h", c, obs, 14'h0);
      end
    end
    reset = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL reset_model E%0d got=%h want=%h", c, obs, exp_vec());
      end
      if (c == 0) begin
        checks++;
        if (obs !== 14'h0) begin
          errors++;
          $display("FAIL reset_release_edge got=%h want=%h", obs, 14'h0);
        end
      end
      if (c == 4) begin
        checks++;
        if (dut_b !== 5'h00) begin
          errors++;
          $display("FAIL reset_early E4 got=%h want=%h", dut_b, 5'h00);
        end
      end
      if (c == 5) begin
        checks++;
        if ({dut_b, any_active, sensor_change} !== 7'h7F) begin
          errors++;
          $display("FAIL reset_e5 got=%h want=%h", {dut_b, any_active, sensor_change}, 7'h7F);
        end
      end
      if (c == 6) begin
        checks++;
        if (sensor_change !== 1'b0) begin
          errors++;
          $display("FAIL reset_pulse_width got=%b want=0", sensor_change);
        end
      end
    end
  endtask

  task automatic test_clean_press();
    int sc_cnt = 0;
    raw_b = '0;
    raw_t = '0;
    do_reset(2);
    repeat (6) tick();
    raw_b[IDX_SFD] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (sensor_change === 1'b1) sc_cnt++;
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL clean_press E%0d got=%h want=%h", c, obs, exp_vec());
      end
      if (c == 4) begin
        checks++;
        if (SFD !== 1'b0) begin
          errors++;
          $display("FAIL clean_press_e4 got=%b want=0", SFD);
        end
      end
      if (c == 5) begin
        checks++;
        if ({SFD, any_active} !== 2'b11) begin
          errors++;
          $display("FAIL clean_press_e5 got=%b want=11", {SFD, any_active});
        end
      end
    end
    checks++;
    if (sc_cnt != 1) begin
      errors++;
      $display("FAIL clean_press_pulses got=%0d want=1", sc_cnt);
    end
  endtask

  task automatic test_glitch();
    int sc_cnt = 0;
    raw_b = '0;
    raw_t = '0;
    do_reset(2);
    repeat (4) tick();
    raw_b[IDX_SW] = 1'b1;
    for (int c = 0; c < 14; c++) begin
      if (c == 3) raw_b[IDX_SW] = 1'b0;
      tick();
      if (sensor_change === 1'b1) sc_cnt++;
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL glitch_short E%0d got=%h want=%h", c, obs, exp_vec());
      end
    end
    checks++;
    if ({SW, sc_cnt[0]} !== 2'b00 || sc_cnt != 0) begin
      errors++;
      $display("FAIL glitch_reject got=SW%b/%0d want=SW0/0", SW, sc_cnt);
    end
    raw_b[IDX_SW] = 1'b1;
    for (int c = 0; c < 14; c++) begin
      if (c == 4) raw_b[IDX_SW] = 1'b0;
      tick();
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL glitch_full E%0d got=%h want=%h", c, obs, exp_vec());
      end
      if (c == 4 || c == 5) begin
        checks++;
        if (SW !== (c == 5)) begin
          errors++;
          $display("FAIL glitch_full_edge E%0d got=%b want=%b", c, SW, (c == 5));
        end
      end
    end
  endtask

  task automatic test_temperature();
    raw_b = '0;
    raw_t = 6'd20;
    do_reset(2);
    repeat (8) tick();
    raw_t = 6'd35;
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL temp_step E%0d got=%h want=%h", c, obs, exp_vec());
      end
      if (c == 3 || c == 4) begin
        checks++;
        if (temperature !== ((c == 4) ? 6'd35 : 6'd20)) begin
          errors++;
          $display("FAIL temp_step_edge E%0d got=%0d want=%0d", c, temperature, (c == 4) ? 35 : 20);
        end
      end
    end
    for (int j = 0; j < 10; j++) begin
      raw_t = (j % 2 == 0) ? 6'd36 : 6'd35;
      tick();
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL temp_alt j=%0d got=%h want=%h", j, obs, exp_vec());
      end
    end
    checks++;
    if (temperature !== 6'd35) begin
      errors++;
      $display("FAIL temp_alt_hold got=%0d want=35", temperature);
    end
    raw_t = 6'd36;
    for (int c = 0; c < 7; c++) begin
      tick();
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL temp_settle E%0d got=%h want=%h", c, obs, exp_vec());
      end
      if (c == 3 || c == 4) begin
        checks++;
        if (temperature !== ((c == 4) ? 6'd36 : 6'd35)) begin
          errors++;
          $display("FAIL temp_settle_edge E%0d got=%0d want=%0d", c, temperature, (c == 4) ? 36 : 35);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    raw_b = '0;
    raw_t = '0;
    do_reset(2);
    repeat (3) tick();
    raw_b[IDX_SFA] = 1'b1;
    repeat (3) tick();
    do_reset(1);
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL reset_mid E%0d got=%h want=%h", c, obs, exp_vec());
      end
      if (c == 4 || c == 5) begin
        checks++;
        if (SFA !== (c == 5)) begin
          errors++;
          $display("FAIL reset_mid_edge E%0d got=%b want=%b", c, SFA, (c == 5));
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    int sc_cnt = 0;
    raw_b = '0;
    raw_t = '0;
    do_reset(2);
    repeat (2) tick();
    raw_b[IDX_SFD] = 1'b1;
    raw_b[IDX_SRD] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (sensor_change === 1'b1) sc_cnt++;
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL simul E%0d got=%h want=%h", c, obs, exp_vec());
      end
      if (c == 4 || c == 5) begin
        checks++;
        if ({SRD, SFD} !== ((c == 5) ? 2'b11 : 2'b00)) begin
          errors++;
          $display("FAIL simul_edge E%0d got=%b want=%b", c, {SRD, SFD}, (c == 5) ? 2'b11 : 2'b00);
        end
      end
    end
    checks++;
    if (sc_cnt != 1) begin
      errors++;
      $display("FAIL simul_pulses got=%0d want=1", sc_cnt);
    end
  endtask

  task automatic test_back_to_back();
    raw_b[IDX_SFD] = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (c == 0) raw_b[IDX_SRD] = 1'b0;
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL b2b E%0d got=%h want=%h", c, obs, exp_vec());
      end
      if (c == 5 || c == 6) begin
        checks++;
        if (sensor_change !== 1'b1) begin
          errors++;
          $display("FAIL b2b_pulse E%0d got=%b want=1", c, sensor_change);
        end
      end
    end
  endtask

  task automatic test_random();
    raw_b = '0;
    raw_t = 6'($urandom);
    do_reset(2);
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 5; i++) begin
        if ($urandom_range(7) == 0) raw_b[i] = ~raw_b[i];
      end
      if ($urandom_range(5) == 0) raw_t = 6'($urandom);
      if ($urandom_range(199) == 0) do_reset(1);
      tick();
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL random cyc=%0d got=%h want=%h", c, obs, exp_vec());
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    raw_b = '0;
    raw_t = '0;
    test_reset();
    test_clean_press();
    test_glitch();
    test_temperature();
    test_reset_mid();
    test_simultaneous();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
